// File: rtl/option_store_ctrl.sv
// Option BRAM controller: stores parser words during board load, keeps a per-line
// base/count table, then serves pipelined (line, option) reads for the solver.
module option_store_ctrl #(
    parameter int MAX_ROWS        = 11,
    parameter int MAX_COLS        = 11,
    parameter int MAX_NUM_OPTIONS = 84,
    parameter int DEPTH           = 1024,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = $clog2(MAX_ROWS + MAX_COLS),
    localparam int OW = $clog2(MAX_NUM_OPTIONS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          write_ready,
    input  logic [15:0]   line,
    input  logic [2:0]    flag,
    input  logic          board_done,
    input  logic          rd_req,
    input  logic [LW-1:0] rd_line,
    input  logic [OW-1:0] rd_opt,
    output logic          rd_ack,
    output logic          rd_valid,
    output logic [15:0]   rd_data,
    output logic          rd_err,
    output logic          bram_we,
    output logic [AW-1:0] bram_addr,
    output logic [15:0]   bram_din,
    input  logic [15:0]   bram_dout,
    output logic          loaded,
    output logic          overflow,
    output logic          busy
);

    localparam int NL = MAX_ROWS + MAX_COLS;
    localparam logic [2:0] FLAG_START = 3'b110;
    localparam logic [2:0] FLAG_END   = 3'b001;
    localparam logic [2:0] FLAG_OR    = 3'b010;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READY, S_ERROR} state_t;

    state_t        r_state;
    state_t        w_next_state;

    logic          r_wr_d;
    logic [AW:0]   r_wr_ptr;
    logic [LW-1:0] r_cur_line;
    logic [AW:0]   r_base [NL];
    logic [AW:0]   r_cnt  [NL];
    logic [2:0]    r_pipe_v;
    logic [2:0]    r_pipe_e;
    logic          r_bram_we;
    logic [AW-1:0] r_bram_addr;
    logic [15:0]   r_bram_din;
    logic          r_loaded;
    logic          r_overflow;

    logic          w_event;
    logic          w_start;
    logic          w_data;
    logic          w_line_bad;
    logic          w_full;
    logic          w_do_write;
    logic          w_do_start;
    logic          w_rd_line_ok;
    logic [LW-1:0] w_rd_idx;
    logic          w_rd_hit;
    logic [AW-1:0] w_rd_addr;
    logic [AW:0]   w_start_base;

    // A held strobe counts once: only the 0->1 transition is an event.
    assign w_event    = write_ready & ~r_wr_d;
    assign w_start    = w_event & (flag == FLAG_START);
    assign w_data     = w_event & ((flag == FLAG_OR) | (flag == FLAG_END));
    assign w_line_bad = (line[15:LW] != '0) || (32'(line[LW-1:0]) >= 32'(NL));
    assign w_full     = (r_wr_ptr == (AW+1)'(DEPTH));

    assign w_do_write   = (r_state == S_LOAD) & w_data & ~w_full;
    assign w_do_start   = (r_state != S_ERROR) & w_start & ~w_line_bad;
    assign w_start_base = (r_state == S_LOAD) ? r_wr_ptr : '0;

    assign w_rd_line_ok = 32'(rd_line) < 32'(NL);
    assign w_rd_idx     = w_rd_line_ok ? rd_line : '0;
    assign w_rd_hit     = w_rd_line_ok && (32'(rd_opt) < 32'(r_cnt[w_rd_idx]));
    assign w_rd_addr    = AW'(r_base[w_rd_idx]) + AW'(rd_opt);

    // NOTE: state lives in flops updated with <= so every reader sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_READY: begin
                if (w_start) w_next_state = w_line_bad ? S_ERROR : S_LOAD;
            end
            S_LOAD: begin
                if ((w_start && w_line_bad) || (w_data && w_full)) w_next_state = S_ERROR;
                else if (board_done)                               w_next_state = S_READY;
            end
            default: w_next_state = S_ERROR;
        endcase
    end

    // Any recognised parser event owns the BRAM port this cycle, so the read loses.
    always_comb begin
        busy   = (r_state == S_LOAD);
        rd_ack = (r_state == S_READY) & rd_req & ~(w_start | w_data);
    end

    // NOTE: the line tables are small register arrays, so they are cleared by reset like any flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_d      <= 1'b0;
            r_wr_ptr    <= '0;
            r_cur_line  <= '0;
            r_pipe_v    <= '0;
            r_pipe_e    <= '0;
            r_bram_we   <= 1'b0;
            r_bram_addr <= '0;
            r_bram_din  <= '0;
            r_loaded    <= 1'b0;
            r_overflow  <= 1'b0;
            for (int i = 0; i < NL; i++) begin
                r_base[i] <= '0;
                r_cnt[i]  <= '0;
            end
        end else begin
            r_wr_d    <= write_ready;
            r_bram_we <= w_do_write;
            r_loaded  <= (w_next_state == S_READY);
            if (w_next_state == S_ERROR) r_overflow <= 1'b1;

            r_pipe_v <= {r_pipe_v[1:0], rd_ack};
            r_pipe_e <= {r_pipe_e[1:0], rd_ack & ~w_rd_hit};

            if (w_do_write) begin
                r_bram_addr         <= r_wr_ptr[AW-1:0];
                r_bram_din          <= line;
                r_wr_ptr            <= r_wr_ptr + (AW+1)'(1);
                r_cnt[r_cur_line]   <= r_cnt[r_cur_line] + (AW+1)'(1);
            end else if (rd_ack && w_rd_hit) begin
                r_bram_addr <= w_rd_addr;
            end

            if (w_do_start) begin
                // A START outside LOAD begins a fresh board from address 0.
                if (r_state != S_LOAD) begin
                    r_wr_ptr <= '0;
                    for (int i = 0; i < NL; i++) r_cnt[i] <= '0;
                end
                r_cur_line               <= line[LW-1:0];
                r_base[line[LW-1:0]]     <= w_start_base;
                r_cnt[line[LW-1:0]]      <= '0;
            end
        end
    end

    assign bram_we   = r_bram_we;
    assign bram_addr = r_bram_addr;
    assign bram_din  = r_bram_din;
    assign loaded    = r_loaded;
    assign overflow  = r_overflow;
    assign rd_valid  = r_pipe_v[2];
    assign rd_err    = r_pipe_e[2];
    assign rd_data   = (r_pipe_v[2] && !r_pipe_e[2]) ? bram_dout : '0;

endmodule

// File: tb/tb_option_store_ctrl.sv
// Directed bench for option_store_ctrl: load, reads, strobe stretch, collision,
// resets, and overflow on a DEPTH=4 instance.
module tb_option_store_ctrl;

    localparam int LW = 5;
    localparam int OW = 7;
    localparam logic [2:0] F_START = 3'b110;
    localparam logic [2:0] F_END   = 3'b001;
    localparam logic [2:0] F_OR    = 3'b010;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, write_ready, board_done, rd_req;
    logic [15:0]   line;
    logic [2:0]    flag;
    logic [LW-1:0] rd_line;
    logic [OW-1:0] rd_opt;

    logic          rd_ack, rd_valid, rd_err, bram_we, loaded, overflow, busy;
    logic [15:0]   rd_data, bram_din, bram_dout;
    logic [9:0]    bram_addr;

    logic          rd_ack4, rd_valid4, rd_err4, bram_we4, loaded4, overflow4, busy4;
    logic [15:0]   rd_data4, bram_din4;
    logic [15:0]   bram_dout4 = 16'h0;
    logic [1:0]    bram_addr4;

    option_store_ctrl dut (
        .clk(clk), .rst(rst), .write_ready(write_ready), .line(line), .flag(flag),
        .board_done(board_done), .rd_req(rd_req), .rd_line(rd_line), .rd_opt(rd_opt),
        .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
        .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din), .bram_dout(bram_dout),
        .loaded(loaded), .overflow(overflow), .busy(busy)
    );

    option_store_ctrl #(.DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .write_ready(write_ready), .line(line), .flag(flag),
        .board_done(board_done), .rd_req(rd_req), .rd_line(rd_line), .rd_opt(rd_opt),
        .rd_ack(rd_ack4), .rd_valid(rd_valid4), .rd_data(rd_data4), .rd_err(rd_err4),
        .bram_we(bram_we4), .bram_addr(bram_addr4), .bram_din(bram_din4), .bram_dout(bram_dout4),
        .loaded(loaded4), .overflow(overflow4), .busy(busy4)
    );

    // BRAM model with two cycles of read latency.
    logic [15:0] mem [1024];
    logic [15:0] r_p1;
    always @(posedge clk) begin
        if (bram_we) mem[bram_addr] <= bram_din;
        r_p1      <= mem[bram_addr];
        bram_dout <= r_p1;
    end

    int we_count = 0, we4_count = 0, valid_count = 0;
    always @(negedge clk) begin
        if (bram_we)  we_count++;
        if (bram_we4) we4_count++;
        if (rd_valid) valid_count++;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] f, input logic [15:0] w, input bit stretch);
        write_ready = 1'b1; flag = f; line = w;
        tick();
        if (stretch) tick();
        write_ready = 1'b0;
        tick();
    endtask

    task automatic finish_board();
        board_done = 1'b1;
        tick();
        board_done = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [LW-1:0] l, input logic [OW-1:0] o,
                           input logic [15:0] exp_d, input logic exp_e, input logic [9:0] exp_a);
        rd_req = 1'b1; rd_line = l; rd_opt = o;
        #1;
        check({tag, "_ack"}, rd_ack, 1);
        tick();
        rd_req = 1'b0;
        if (!exp_e) check({tag, "_addr"}, bram_addr, exp_a);
        check({tag, "_early"}, rd_valid, 0);
        tick();
        tick();
        check({tag, "_valid"}, rd_valid, 1);
        check({tag, "_err"}, rd_err, exp_e);
        check({tag, "_data"}, rd_data, exp_d);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_flags"}, {rd_ack, rd_valid, rd_err, bram_we, loaded, overflow, busy}, 0);
        check({tag, "_rd_data"}, rd_data, 0);
        check({tag, "_bram_addr"}, bram_addr, 0);
        check({tag, "_bram_din"}, bram_din, 0);
    endtask

    int base_we, base_v;

    initial begin
        rst = 1'b1; write_ready = 1'b0; board_done = 1'b0; rd_req = 1'b0;
        line = '0; flag = '0; rd_line = '0; rd_opt = '0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Two-line board
        base_we = we_count;
        send(F_START, 16'd0, 0);
        check("load_busy", busy, 1);
        send(F_OR,    16'h0005, 0);
        send(F_END,   16'h000A, 0);
        send(F_START, 16'd1, 0);
        send(F_END,   16'h0003, 0);
        check("load_not_loaded", loaded, 0);
        finish_board();
        check("load_loaded", loaded, 1);
        check("load_idle_busy", busy, 0);
        check("load_we_count", we_count - base_we, 3);
        check("mem0", mem[0], 16'h0005);
        check("mem1", mem[1], 16'h000A);
        check("mem2", mem[2], 16'h0003);

        do_read("rd10", 5'd1, 7'd0, 16'h0003, 1'b0, 10'd2);
        do_read("rd01", 5'd0, 7'd1, 16'h000A, 1'b0, 10'd1);
        do_read("rd02_oob", 5'd0, 7'd2, 16'h0000, 1'b1, 10'd0);

        // Back-to-back reads keep order
        rd_req = 1'b1; rd_line = 5'd0; rd_opt = 7'd0;
        tick();
        rd_line = 5'd1; rd_opt = 7'd0;
        tick();
        rd_line = 5'd0; rd_opt = 7'd1;
        tick();
        rd_req = 1'b0;
        check("pipe0", {rd_valid, rd_data}, {1'b1, 16'h0005});
        tick();
        check("pipe1", {rd_valid, rd_data}, {1'b1, 16'h0003});
        tick();
        check("pipe2", {rd_valid, rd_data}, {1'b1, 16'h000A});
        tick();
        check("pipe_done", rd_valid, 0);

        // START event colliding with a read request in READY
        rd_req = 1'b1; rd_line = 5'd0; rd_opt = 7'd0;
        write_ready = 1'b1; flag = F_START; line = 16'd0;
        #1;
        check("collide_ack", rd_ack, 0);
        tick();
        rd_req = 1'b0; write_ready = 1'b0;
        check("reload_busy", busy, 1);
        check("reload_loaded", loaded, 0);
        tick();

        // Stretched strobe gives one write; pointer restarts at 0 for the new board
        base_we = we_count;
        send(F_OR, 16'h1111, 1);
        check("stretch_one_we", we_count - base_we, 1);
        send(F_OR, 16'h2222, 0);
        check("stretch_mem0", mem[0], 16'h1111);
        check("stretch_mem1", mem[1], 16'h2222);

        // Reset in the middle of a load
        send(F_OR, 16'h3333, 0);
        rst = 1'b1;
        tick();
        check_all_zero("rst_mid");
        rst = 1'b0;
        tick();
        base_we = we_count;
        send(F_START, 16'd2, 0);
        send(F_OR, 16'h4444, 0);
        check("reload_we", we_count - base_we, 1);
        check("reload_addr", bram_addr, 0);
        check("reload_mem0", mem[0], 16'h4444);
        finish_board();
        do_read("rd20", 5'd2, 7'd0, 16'h4444, 1'b0, 10'd0);

        // Reset with a read in flight
        rd_req = 1'b1; rd_line = 5'd2; rd_opt = 7'd0;
        tick();
        rd_req = 1'b0;
        base_v = valid_count;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        repeat (4) tick();
        check("flush_no_valid", valid_count - base_v, 0);

        // Overflow on the DEPTH=4 instance
        send(F_START, 16'd0, 0);
        base_we = we4_count;
        for (int i = 0; i < 5; i++) send(F_OR, 16'(i + 16'h0100), 0);
        check("ovf_writes", we4_count - base_we, 4);
        check("ovf_flag", overflow4, 1);
        check("ovf_not_busy", busy4, 0);
        check("ovf_not_loaded", loaded4, 0);
        check("big_no_ovf", overflow, 0);
        finish_board();
        check("ovf_ignores_done", loaded4, 0);
        rd_req = 1'b1; rd_line = 5'd0; rd_opt = 7'd0;
        #1;
        check("ovf_no_ack", rd_ack4, 0);
        tick();
        rd_req = 1'b0;

        // Out-of-range START line sends the big instance to ERROR, which then holds
        send(F_START, 16'd22, 0);
        check("badline_ovf", overflow, 1);
        check("badline_busy", busy, 0);
        send(F_START, 16'd0, 0);
        check("error_holds", {overflow, busy, loaded}, 3'b100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
